// File: rtl/rv_alu2.sv
// Second ALU pipeline stage: stage register, ALU, branch resolution and the
// wrong-path kill counter that drops instructions fetched before a redirect.

package rv_alu2_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  // alu_res marks a register-relative jump target (jalr) when inst_jal_jalr=1.
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    alu_op_e     alu_ctrl;
    logic        alu_res;
    logic        store;
    logic        reg_write;
    logic [4:0]  rd;
    logic        inst_jal_jalr;
    logic        inst_branch;
    logic [31:0] pc;
    logic [31:0] pc_target;
    logic [1:0]  res_src;
    logic [2:0]  funct3;
    logic [31:0] reg_data2;
    logic        compressed;
  } alu1_bus_t;

  typedef struct packed {
    logic [31:0] result;
    logic        reg_write;
    logic [4:0]  rd;
    logic        store;
    logic [1:0]  res_src;
    logic [2:0]  funct3;
    logic [31:0] reg_data2;
    logic [31:0] pc_p4;
    logic        valid;
  } alu2_bus_t;

endpackage

module rv_alu2
  import rv_alu2_pkg::*;
#(
  parameter int unsigned KILL_SLOTS = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  alu1_bus_t   i_bus,
  output alu2_bus_t   o_bus,
  output logic        o_pc_select,
  output logic [31:0] o_pc_target
);

  localparam logic [1:0] KillInit = 2'(KILL_SLOTS);

  alu1_bus_t   stage_q, stage_d;
  logic        valid_q, valid_d;
  logic [1:0]  kill_q, kill_d;
  alu1_bus_t   bubble;
  logic [31:0] alu_out;
  logic [31:0] pc_p4;
  logic        taken;
  logic [4:0]  shamt;

  // Incoming instruction with every architecturally visible side effect removed.
  always_comb begin
    bubble               = i_bus;
    bubble.store         = 1'b0;
    bubble.reg_write     = 1'b0;
    bubble.inst_branch   = 1'b0;
    bubble.inst_jal_jalr = 1'b0;
  end

  // Next-state: flush beats stall; a non-zero kill counter turns captures into bubbles.
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    if (i_flush) begin
      stage_d = bubble;
      valid_d = 1'b0;
      kill_d  = 2'd0;
    end else if (!i_stall) begin
      if (kill_q != 2'd0) begin
        stage_d = bubble;
        valid_d = 1'b0;
        kill_d  = kill_q - 2'd1;
      end else begin
        stage_d = i_bus;
        valid_d = 1'b1;
      end
      // A fresh redirect restarts the drop window.
      if (o_pc_select) begin
        kill_d = KillInit;
      end
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stage_q <= '0;
      valid_q <= 1'b0;
      kill_q  <= 2'd0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
    end
  end

  assign shamt = stage_q.op2[4:0];

  // ALU on the captured operands.
  always_comb begin
    alu_out = '0;
    case (stage_q.alu_ctrl)
      AluAdd:  alu_out = stage_q.op1 + stage_q.op2;
      AluSub:  alu_out = stage_q.op1 - stage_q.op2;
      AluAnd:  alu_out = stage_q.op1 & stage_q.op2;
      AluOr:   alu_out = stage_q.op1 | stage_q.op2;
      AluXor:  alu_out = stage_q.op1 ^ stage_q.op2;
      AluSll:  alu_out = stage_q.op1 << shamt;
      AluSrl:  alu_out = stage_q.op1 >> shamt;
      AluSra:  alu_out = 32'($signed(stage_q.op1) >>> shamt);
      AluSlt:  alu_out = {31'd0, $signed(stage_q.op1) < $signed(stage_q.op2)};
      AluSltu: alu_out = {31'd0, stage_q.op1 < stage_q.op2};
      default: alu_out = '0;
    endcase
  end

  assign pc_p4 = stage_q.pc + (stage_q.compressed ? 32'd2 : 32'd4);

  // Branch condition from funct3; unused encodings never take.
  always_comb begin
    taken = 1'b0;
    case (stage_q.funct3)
      3'b000:  taken = (stage_q.op1 == stage_q.op2);
      3'b001:  taken = (stage_q.op1 != stage_q.op2);
      3'b100:  taken = ($signed(stage_q.op1) < $signed(stage_q.op2));
      3'b101:  taken = ($signed(stage_q.op1) >= $signed(stage_q.op2));
      3'b110:  taken = (stage_q.op1 < stage_q.op2);
      3'b111:  taken = (stage_q.op1 >= stage_q.op2);
      default: taken = 1'b0;
    endcase
  end

  // Redirect is suppressed while stalled so a held jump fires exactly once.
  always_comb begin
    o_pc_select = valid_q & ~i_stall &
                  (stage_q.inst_jal_jalr | (stage_q.inst_branch & taken));
    o_pc_target = stage_q.pc_target;
    if (stage_q.inst_jal_jalr && stage_q.alu_res) begin
      o_pc_target = {stage_q.pc_target[31:1], 1'b0};
    end
  end

  // Output bus driven straight from the stage register.
  always_comb begin
    o_bus           = '0;
    o_bus.result    = stage_q.inst_jal_jalr ? pc_p4 : alu_out;
    o_bus.reg_write = stage_q.reg_write;
    o_bus.rd        = stage_q.rd;
    o_bus.store     = stage_q.store;
    o_bus.res_src   = stage_q.res_src;
    o_bus.funct3    = stage_q.funct3;
    o_bus.reg_data2 = stage_q.reg_data2;
    o_bus.pc_p4     = pc_p4;
    o_bus.valid     = valid_q;
  end

endmodule
